// File: rtl/aes_inv_key_sched.sv
// AES-128 round-key walker: steps from a loaded round-10 key towards round 0, one byte per cycle.
// Optional macro AES_KEY_FWD_EN adds a dir input for stepping forward (round_idx+1).
module aes_inv_key_sched (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [127:0] key_in,
    input  logic         next,
`ifdef AES_KEY_FWD_EN
    input  logic         dir,
`endif
    output logic [127:0] round_key_out,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    output logic         busy,
    output logic         err
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [0:15][7:0]   key_q, key_d;
    logic [3:0]         idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               fwd;
    logic               accept;

    logic [1:0]         step, j, jn;
    logic [3:0]         dst, src;
    logic [7:0]         sb_out, rc, operand;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8); maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

`ifdef AES_KEY_FWD_EN
    logic dir_q, dir_d;
    assign fwd    = dir_q;
    assign accept = valid_q && (dir ? (idx_q != 4'd10) : (idx_q != 4'd0));
`else
    assign fwd    = 1'b0;
    assign accept = valid_q && (idx_q != 4'd0);
`endif

    // Step 0 is the SubWord/Rcon update of w0; step k (1..3) does w[k] ^= w[k-1].
    // Forward order is steps 0,1,2,3; inverse order is 3,2,1,0 (step = ~phase).
    always_comb begin
        j       = cnt_q[1:0];
        jn      = j + 2'd1;
        step    = fwd ? cnt_q[3:2] : ~cnt_q[3:2];
        dst     = {step, j};
        src     = {step - 2'd1, j};
        sb_out  = sbox(key_q[{2'b11, jn}]);
        rc      = rcon(fwd ? idx_q + 4'd1 : idx_q);
        operand = (step == 2'd0) ? (sb_out ^ ((j == 2'd0) ? rc : 8'h00)) : key_q[src];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        err_d   = 1'b0;
`ifdef AES_KEY_FWD_EN
        dir_d   = dir_q;
`endif
        if (load) begin
            key_d   = key_in;
            idx_d   = 4'd10;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = '0;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (next) begin
                        if (accept) begin
                            state_d = CALC;
                            valid_d = 1'b0;
                            busy_d  = 1'b1;
                            cnt_d   = '0;
`ifdef AES_KEY_FWD_EN
                            dir_d   = dir;
`endif
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                CALC: begin
                    err_d      = next;
                    key_d[dst] = key_q[dst] ^ operand;
                    cnt_d      = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                    end
                end
                DONE: begin
                    err_d   = next;
                    idx_d   = fwd ? idx_q + 4'd1 : idx_q - 4'd1;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            key_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef AES_KEY_FWD_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
`ifdef AES_KEY_FWD_EN
            dir_q   <= dir_d;
`endif
        end
    end

    assign round_key_out = key_q;
    assign round_idx     = idx_q;
    assign key_valid     = valid_q;
    assign busy          = busy_q;
    assign err           = err_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed bench for aes_inv_key_sched using FIPS-197 AES-128 key expansion vectors.
module tb_aes_inv_key_sched;

    localparam logic [127:0] K10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] K9   = 128'h549932d1f08557681093ed9cbe2c974e;
    localparam logic [127:0] K0   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KNEW = 128'h00112233445566778899aabbccddeeff;
`ifdef AES_KEY_FWD_EN
    localparam logic [127:0] K1   = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         load = 1'b0;
    logic [127:0] key_in = '0;
    logic         next = 1'b0;
`ifdef AES_KEY_FWD_EN
    logic         dir = 1'b0;
`endif
    logic [127:0] round_key_out;
    logic [3:0]   round_idx;
    logic         key_valid;
    logic         busy;
    logic         err;

    int checks = 0;
    int errors = 0;
    int lat;
    int bcnt;

    always #5 clk = ~clk;

    aes_inv_key_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (load),
        .key_in        (key_in),
        .next          (next),
`ifdef AES_KEY_FWD_EN
        .dir           (dir),
`endif
        .round_key_out (round_key_out),
        .round_idx     (round_idx),
        .key_valid     (key_valid),
        .busy          (busy),
        .err           (err)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse next, then wait (bounded) for key_valid; lat counts edges after acceptance.
    task automatic run_next(output int l, output int b);
        next = 1'b1;
        tick();
        next = 1'b0;
        b = busy ? 1 : 0;
        l = 0;
        while (!key_valid && l < 40) begin
            tick();
            l++;
            if (busy) b++;
        end
    endtask

    task automatic do_load(input logic [127:0] k);
        load   = 1'b1;
        key_in = k;
        tick();
        load   = 1'b0;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #2;
        check("rst_key", round_key_out, '0);
        check("rst_idx", round_idx, 0);
        check("rst_valid", key_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        tick();
        rst_n = 1'b1;
        tick();

        do_load(K10);
        check("load_valid", key_valid, 1);
        check("load_idx", round_idx, 10);
        check("load_key", round_key_out, K10);
        check("load_busy", busy, 0);

        run_next(lat, bcnt);
        check("r9_lat", lat, 17);
        check("r9_busy_cycles", bcnt, 16);
        check("r9_idx", round_idx, 9);
        check("r9_key", round_key_out, K9);
        check("r9_valid", key_valid, 1);

        // next while CALC is running: rejected, CALC keeps going
        next = 1'b1;
        tick();
        next = 1'b0;
        check("calc_busy", busy, 1);
        check("calc_valid", key_valid, 0);
        tick();
        tick();
        next = 1'b1;
        tick();
        next = 1'b0;
        check("calc_next_err", err, 1);
        check("calc_next_busy", busy, 1);
        check("calc_next_idx", round_idx, 9);
        tick();
        check("calc_err_clear", err, 0);
        lat = 4;
        while (!key_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("r8_lat", lat, 17);
        check("r8_idx", round_idx, 8);

        for (int i = 7; i >= 0; i--) begin
            run_next(lat, bcnt);
            check("chain_lat", lat, 17);
            check("chain_busy_cycles", bcnt, 16);
            check("chain_idx", round_idx, 4'(i));
        end
        check("r0_key", round_key_out, K0);

        next = 1'b1;
        tick();
        next = 1'b0;
        check("r0_next_err", err, 1);
        check("r0_next_idx", round_idx, 0);
        check("r0_next_key", round_key_out, K0);
        check("r0_next_valid", key_valid, 1);
        tick();
        check("r0_err_clear", err, 0);

`ifdef AES_KEY_FWD_EN
        dir = 1'b1;
        run_next(lat, bcnt);
        check("fwd_lat", lat, 17);
        check("fwd_idx", round_idx, 1);
        check("fwd_key", round_key_out, K1);
        dir = 1'b0;
        run_next(lat, bcnt);
        check("back_idx", round_idx, 0);
        check("back_key", round_key_out, K0);
        do_load(K10);
        dir = 1'b1;
        next = 1'b1;
        tick();
        next = 1'b0;
        dir = 1'b0;
        check("fwd_r10_err", err, 1);
        check("fwd_r10_idx", round_idx, 10);
        check("fwd_r10_key", round_key_out, K10);
`endif

        // load during CALC cycle 7 aborts the derivation
        do_load(K10);
        next = 1'b1;
        tick();
        next = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("abort_pre_busy", busy, 1);
        do_load(KNEW);
        check("abort_idx", round_idx, 10);
        check("abort_valid", key_valid, 1);
        check("abort_key", round_key_out, KNEW);
        check("abort_busy", busy, 0);

        // load and next together: load wins, no err
        load   = 1'b1;
        next   = 1'b1;
        key_in = K10;
        tick();
        load = 1'b0;
        next = 1'b0;
        check("both_err", err, 0);
        check("both_key", round_key_out, K10);
        check("both_idx", round_idx, 10);
        check("both_busy", busy, 0);
        tick();
        check("both_stay_idle", busy, 0);

        // asynchronous reset during CALC
        next = 1'b1;
        tick();
        next = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_key", round_key_out, '0);
        check("arst_idx", round_idx, 0);
        check("arst_valid", key_valid, 0);
        check("arst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        next = 1'b1;
        tick();
        next = 1'b0;
        check("post_rst_err", err, 1);
        check("post_rst_busy", busy, 0);
        check("post_rst_valid", key_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
